// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the 16-bit core.
//   2 asynchronous read ports, 2 synchronous write ports (port 1 wins on an
//   address collision), optional same-cycle write->read bypass, optional
//   hardwired zero register, a per-register busy scoreboard, and a sequential
//   post-reset clear engine that sweeps the array once before raising ready.
// Ports:
//   clk                 clock, all state updates on posedge
//   rst                 synchronous active-high reset (restarts the clear)
//   ready               1 = clear done, writes/busy_set accepted
//   rs1, rs2            read addresses
//   rdata1, rdata2      read data (combinational)
//   we0/wa0/wd0         write port 0
//   we1/wa1/wd1         write port 1
//   busy_set/busy_addr  mark busy_addr as having a pending producer
//   busy1, busy2        scoreboard state of rs1 / rs2 (combinational)
module reg_file_mp #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             busy1,
    output logic             busy2
);
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic             state;
    logic [AW-1:0]    clr_ptr;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Writes / busy_set aimed at the hardwired zero register are dropped
    // entirely, so they neither update the array nor touch the scoreboard.
    logic wr0_eff, wr1_eff, set_eff;
    assign wr0_eff = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_eff = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign set_eff = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    // Writes retire their producer; a same-cycle busy_set is a newly issued
    // producer for that register, so it is applied last and wins.
    always_comb begin
        busy_nxt = busy;
        if (wr0_eff) busy_nxt[wa0] = 1'b0;
        if (wr1_eff) busy_nxt[wa1] = 1'b0;
        if (set_eff) busy_nxt[busy_addr] = 1'b1;
    end

    // The array is deliberately not reset in one go; the clear engine
    // zeroes one entry per cycle after rst is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
            busy    <= '0;
        end else if (state == ST_CLEAR) begin
            regs[clr_ptr] <= '0;
            clr_ptr       <= clr_ptr + 1'b1;
            if (clr_ptr == LAST) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end else begin
            if (wr0_eff) regs[wa0] <= wd0;
            if (wr1_eff) regs[wa1] <= wd1;   // later assignment: port 1 wins
            busy <= busy_nxt;
        end
    end

    // Read ports share one mux structure; port 1 has forwarding priority to
    // match the array's write-collision rule.
    logic [1:0][AW-1:0]    rs_a;
    logic [1:0][WIDTH-1:0] rd_a;
    logic [1:0]            bz_a;
    assign rs_a = {rs2, rs1};

    always_comb begin
        rd_a = '0;
        bz_a = '0;
        for (int p = 0; p < 2; p++) begin
            rd_a[p] = regs[rs_a[p]];
            bz_a[p] = busy[rs_a[p]];
            if (BYPASS != 0) begin
                if (we1 && wa1 == rs_a[p]) begin
                    rd_a[p] = wd1;
                    bz_a[p] = 1'b0;
                end else if (we0 && wa0 == rs_a[p]) begin
                    rd_a[p] = wd0;
                    bz_a[p] = 1'b0;
                end
            end
            if (state == ST_CLEAR || ((ZERO_REG != 0) && rs_a[p] == '0)) begin
                rd_a[p] = '0;
                bz_a[p] = 1'b0;
            end
        end
    end

    assign rdata1 = rd_a[0];
    assign rdata2 = rd_a[1];
    assign busy1  = bz_a[0];
    assign busy2  = bz_a[1];
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    localparam int W = 16;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [A-1:0] rs1, rs2, wa0, wa1, busy_addr;
    logic [W-1:0] wd0, wd1;
    logic         we0, we1, busy_set;

    logic         ready_b, busy1_b, busy2_b, ready_n, busy1_n, busy2_n;
    logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

    always #5 clk = ~clk;

    reg_file_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .rs1(rs1), .rs2(rs2),
        .rdata1(rd1_b), .rdata2(rd2_b), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy1(busy1_b), .busy2(busy2_b));

    reg_file_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n), .rs1(rs1), .rs2(rs2),
        .rdata1(rd1_n), .rdata2(rd2_n), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy1(busy1_n), .busy2(busy2_n));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: architectural contents, scoreboard and clear progress.
    logic [W-1:0] m_regs [D];
    bit           m_busy [D];
    bit           clearing = 1'b1;
    int           clr_n = 0;
    bit           m_ready = 1'b0;
    bit           chk_en = 1'b0;

    // Sampled outputs from the most recent cycle, for directed checks.
    logic [W-1:0] o_rd1_b, o_rd1_n;
    logic         o_bz1_b, o_bz1_n;

    function automatic bit written(input logic [A-1:0] a);
        return !clearing && ((we0 && wa0 == a && a != 0) || (we1 && wa1 == a && a != 0));
    endfunction

    // Bypassed read = value the register will hold after this edge.
    function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a, input bit byp);
        logic [W-1:0] nxt [D];
        if (clearing || a == 0) return '0;
        nxt = m_regs;
        if (we0 && wa0 != 0) nxt[wa0] = wd0;
        if (we1 && wa1 != 0) nxt[wa1] = wd1;
        return byp ? nxt[a] : m_regs[a];
    endfunction

    function automatic bit exp_bz(input logic [A-1:0] a, input bit byp);
        if (clearing) return 1'b0;
        if (byp && written(a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            clearing = 1'b1;
            clr_n    = 0;
            m_ready  = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (clearing) begin
            m_regs[clr_n] = '0;
            clr_n++;
            if (clr_n == D) begin
                clearing = 1'b0;
                m_ready  = 1'b1;
            end
        end else begin
            if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
    endtask

    task automatic cyc(input bit r, input bit w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                       input bit w1, input logic [A-1:0] a1, input logic [W-1:0] d1,
                       input bit bs, input logic [A-1:0] ba,
                       input logic [A-1:0] r1, input logic [A-1:0] r2);
        @(negedge clk);
        rst = r; we0 = w0; wa0 = a0; wd0 = d0; we1 = w1; wa1 = a1; wd1 = d1;
        busy_set = bs; busy_addr = ba; rs1 = r1; rs2 = r2;
        #1;
        o_rd1_b = rd1_b; o_rd1_n = rd1_n; o_bz1_b = busy1_b; o_bz1_n = busy1_n;
        if (chk_en) begin
            chk("ready", {31'b0, ready_b}, {31'b0, m_ready});
            chk("ready_nobyp", {31'b0, ready_n}, {31'b0, m_ready});
            chk("rdata1", {16'b0, rd1_b}, {16'b0, exp_rd(r1, 1'b1)});
            chk("rdata2", {16'b0, rd2_b}, {16'b0, exp_rd(r2, 1'b1)});
            chk("rdata1_nobyp", {16'b0, rd1_n}, {16'b0, exp_rd(r1, 1'b0)});
            chk("rdata2_nobyp", {16'b0, rd2_n}, {16'b0, exp_rd(r2, 1'b0)});
            chk("busy1", {31'b0, busy1_b}, {31'b0, exp_bz(r1, 1'b1)});
            chk("busy2", {31'b0, busy2_b}, {31'b0, exp_bz(r2, 1'b1)});
            chk("busy1_nobyp", {31'b0, busy1_n}, {31'b0, exp_bz(r1, 1'b0)});
            chk("busy2_nobyp", {31'b0, busy2_n}, {31'b0, exp_bz(r2, 1'b0)});
        end
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
    endtask

    task automatic idle(input logic [A-1:0] r1, input logic [A-1:0] r2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Counts edges after release until ready; bounded so a stuck DUT still
    // reaches the summary.
    task automatic wait_ready(input string tag, input bit poke);
        int n;
        for (n = 1; n <= 20; n++) begin
            if (poke) cyc(0, 1, 6, 16'hBEEF, 1, 7, 16'hCAFE, 1, 6, 6, 7);
            else      idle(A'(n % D), 0);
            #1;
            if (ready_b) break;
        end
        chk(tag, n, 8);
    endtask

    initial begin
        rst = 1'b1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        busy_set = 0; busy_addr = 0; rs1 = 0; rs2 = 0;
        foreach (m_regs[i]) m_regs[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;

        // T1: reset and clear sweep
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_ready_after_rst", {31'b0, ready_b}, 32'd0);
        wait_ready("t1_ready_edges", 1'b0);
        for (int i = 0; i < D; i++) begin
            idle(A'(i), A'(D - 1 - i));
            chk("t1_reg_zero", {16'b0, o_rd1_b}, 32'd0);
        end

        // T2: dual write collision, port 1 wins
        cyc(0, 1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0, 3, 0);
        idle(3, 3);
        chk("t2_collision", {16'b0, o_rd1_n}, 32'h5555);

        // T3: bypass vs no bypass
        cyc(0, 1, 5, 16'h1111, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 5, 0);
        chk("t3_bypass", {16'b0, o_rd1_b}, 32'h1234);
        chk("t3_nobyp_old", {16'b0, o_rd1_n}, 32'h1111);
        idle(5, 0);
        chk("t3_nobyp_new", {16'b0, o_rd1_n}, 32'h1234);

        // T4: zero register
        cyc(0, 1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);
        chk("t4_zero_rd", {16'b0, o_rd1_b}, 32'd0);
        chk("t4_zero_busy", {31'b0, o_bz1_b}, 32'd0);

        // T5: scoreboard
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        idle(2, 0);
        chk("t5_busy_set", {31'b0, o_bz1_b}, 32'd1);
        cyc(0, 0, 0, 0, 1, 2, 16'h0202, 1, 2, 2, 0);
        chk("t5_fwd_busy0", {31'b0, o_bz1_b}, 32'd0);
        idle(2, 0);
        chk("t5_set_wins", {31'b0, o_bz1_b}, 32'd1);
        cyc(0, 1, 2, 16'h2222, 0, 0, 0, 0, 0, 2, 0);
        chk("t5_nobyp_still_busy", {31'b0, o_bz1_n}, 32'd1);
        idle(2, 0);
        chk("t5_busy_cleared", {31'b0, o_bz1_b}, 32'd0);
        chk("t5_busy_cleared_nobyp", {31'b0, o_bz1_n}, 32'd0);

        // T6: reset mid-clear, writes during clear are dropped
        cyc(0, 1, 6, 16'h6666, 1, 7, 16'h7777, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 6, 16'hBEEF, 1, 7, 16'hCAFE, 1, 6, 6, 7);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_ready("t6_ready_edges", 1'b1);
        idle(6, 7);
        chk("t6_reg6_cleared", {16'b0, o_rd1_b}, 32'd0);
        chk("t6_busy6_clear", {31'b0, o_bz1_b}, 32'd0);

        // Random traffic, occasional reset
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 149) == 0,
                1'($urandom), A'($urandom), W'($urandom),
                1'($urandom), A'($urandom), W'($urandom),
                1'($urandom), A'($urandom), A'($urandom), A'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
